// File: rtl/des_round_ctrl.sv
// Round sequencer for an iterative DES datapath: load, 16 key-scheduled rounds,
// final swap/FP, then a one-cycle done pulse.
module des_round_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       decrypt,
  input  logic       stall,
  output logic       ready,
  output logic       busy,
  output logic       load_en,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       final_swap,
  output logic       done
);

  // state  | meaning
  // IDLE   | waiting for start, ready=1
  // LOAD   | datapath captures IP block and PC-1 key halves
  // ROUND  | one Feistel round per non-stalled cycle, round_idx 0..15
  // FINAL  | R16/L16 swap and FP into the output register
  // DONE   | result valid, one-cycle pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] idx_q, idx_nxt;
  logic       dir_q, dir_nxt;

  // Decryption rotates right, so the first round needs no rotation at all.
  function automatic logic [1:0] shift_sched(input logic [3:0] idx, input logic dir);
    logic [1:0] sh;
    case (idx)
      4'd0:                 sh = dir ? 2'd0 : 2'd1;
      4'd1, 4'd8, 4'd15:    sh = 2'd1;
      default:              sh = 2'd2;
    endcase
    return sh;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx_q <= 4'd0;
      dir_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      dir_q <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx_q;
    dir_nxt    = dir_q;
    ready      = 1'b0;
    busy       = 1'b0;
    load_en    = 1'b0;
    round_en   = 1'b0;
    key_shift  = 2'd0;
    final_swap = 1'b0;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          dir_nxt   = decrypt;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        load_en = 1'b1;
        idx_nxt = 4'd0;
        if (!stall) state_nxt = S_ROUND;
      end
      S_ROUND: begin
        busy      = 1'b1;
        round_en  = !stall;
        key_shift = shift_sched(idx_q, dir_q);
        if (!stall) begin
          // 4-bit counter wraps 15 -> 0 on the last round
          idx_nxt = idx_q + 4'd1;
          if (idx_q == 4'd15) state_nxt = S_FINAL;
        end
      end
      S_FINAL: begin
        busy       = 1'b1;
        final_swap = 1'b1;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign round_idx = idx_q;
  assign key_dir   = dir_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboard bench for des_round_ctrl: expected load/round/final/done events are
// queued with the stimulus and consumed by a negedge monitor.
module tb_des_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, decrypt, stall;
  logic       ready, busy, load_en, round_en, key_dir, final_swap, done;
  logic [3:0] round_idx;
  logic [1:0] key_shift;

  des_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .stall(stall),
    .ready(ready), .busy(busy), .load_en(load_en), .round_en(round_en),
    .round_idx(round_idx), .key_shift(key_shift), .key_dir(key_dir),
    .final_swap(final_swap), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    int         c;
    logic [3:0] idx;
    logic [1:0] sh;
    logic       dir;
  } rnd_t;

  rnd_t exp_round[$];
  int   exp_load[$], exp_final[$], exp_done[$];

  logic [1:0] enc_sched [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  logic [1:0] dec_sched [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Monitor: per-cycle invariants plus scoreboard pops on every output event.
  always @(negedge clk) begin
    int   e;
    rnd_t r, g;
    total++;
    if ($countones({load_en, round_en, final_swap, done}) > 1) begin
      bad++;
      $display("FAIL excl: cyc=%0d load=%b round=%b final=%b done=%b (at most one required)",
               cyc, load_en, round_en, final_swap, done);
    end
    total++;
    if ($countones({ready, busy, done}) != 1) begin
      bad++;
      $display("FAIL state_flags: cyc=%0d ready=%b busy=%b done=%b (exactly one required)",
               cyc, ready, busy, done);
    end
    total++;
    if ((ready || load_en || final_swap || done) && key_shift !== 2'd0) begin
      bad++;
      $display("FAIL shift_idle: cyc=%0d key_shift=%0d required=0", cyc, key_shift);
    end
    if (load_en) begin
      total++;
      if (exp_load.size() == 0) begin
        bad++;
        $display("FAIL load_unexp: load_en at cyc=%0d, none expected", cyc);
      end else begin
        e = exp_load.pop_front();
        if (e !== cyc) begin
          bad++;
          $display("FAIL load_cyc: got cyc=%0d required=%0d", cyc, e);
        end
      end
    end
    if (round_en) begin
      total++;
      g = '{c: cyc, idx: round_idx, sh: key_shift, dir: key_dir};
      if (exp_round.size() == 0) begin
        bad++;
        $display("FAIL round_unexp: round_en at cyc=%0d idx=%0d, none expected", cyc, round_idx);
      end else begin
        r = exp_round.pop_front();
        if (g !== r) begin
          bad++;
          $display("FAIL round: got cyc=%0d idx=%0d sh=%0d dir=%b required cyc=%0d idx=%0d sh=%0d dir=%b",
                   g.c, g.idx, g.sh, g.dir, r.c, r.idx, r.sh, r.dir);
        end
      end
    end
    if (final_swap) begin
      total++;
      if (exp_final.size() == 0) begin
        bad++;
        $display("FAIL final_unexp: final_swap at cyc=%0d, none expected", cyc);
      end else begin
        e = exp_final.pop_front();
        if (e !== cyc) begin
          bad++;
          $display("FAIL final_cyc: got cyc=%0d required=%0d", cyc, e);
        end
      end
    end
    if (done) begin
      total++;
      if (exp_done.size() == 0) begin
        bad++;
        $display("FAIL done_unexp: done at cyc=%0d, none expected", cyc);
      end else begin
        e = exp_done.pop_front();
        if (e !== cyc) begin
          bad++;
          $display("FAIL done_cyc: got cyc=%0d required=%0d", cyc, e);
        end
      end
    end
  end

  task automatic go_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int c0, input int r);
    while (cyc < c0 + r) go_cycle();
  endtask

  task automatic push_rounds(input int base, input logic dir, input int stall_idx,
                             input int stall_len, input int n);
    for (int i = 0; i < n; i++) begin
      rnd_t r;
      r.c   = base + i + ((i >= stall_idx) ? stall_len : 0);
      r.idx = i[3:0];
      r.sh  = dir ? dec_sched[i] : enc_sched[i];
      r.dir = dir;
      exp_round.push_back(r);
    end
  endtask

  function automatic int pending();
    return exp_load.size() + exp_round.size() + exp_final.size() + exp_done.size();
  endfunction

  task automatic test_reset();
    logic [12:0] got;
    rst = 1'b1; start = 1'b1; decrypt = 1'b1; stall = 1'b1;
    go_cycle();
    go_cycle();
    @(negedge clk);
    got = {ready, busy, load_en, round_en, final_swap, done, key_dir, key_shift, round_idx};
    total++;
    if (got !== 13'b1_0_0_0_0_0_0_00_0000) begin
      bad++;
      $display("FAIL reset_outputs: got=%b required=%b", got, 13'b1_0_0_0_0_0_0_00_0000);
    end
    go_cycle();
    rst = 1'b0; start = 1'b0; decrypt = 1'b0; stall = 1'b0;
    go_cycle();
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || load_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: ready=%b load_en=%b required ready=1 load_en=0", ready, load_en);
    end
  endtask

  task automatic test_encrypt();
    int c0;
    go_cycle();
    c0 = cyc;
    start = 1'b1; decrypt = 1'b0;
    exp_load.push_back(c0 + 1);
    push_rounds(c0 + 2, 1'b0, 99, 0, 16);
    exp_final.push_back(c0 + 18);
    exp_done.push_back(c0 + 19);
    go_cycle();
    start = 1'b0;
    @(negedge clk);
    total++;
    if (round_idx !== 4'd0 || key_dir !== 1'b0) begin
      bad++;
      $display("FAIL enc_load: idx=%0d dir=%b required idx=0 dir=0", round_idx, key_dir);
    end
    wait_rel(c0, 20);
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL enc_ready20: ready=%b required=1", ready);
    end
    total++;
    if (pending() != 0) begin
      bad++;
      $display("FAIL enc_pending: pending=%0d required=0", pending());
    end
  endtask

  task automatic test_decrypt();
    int c0;
    go_cycle();
    c0 = cyc;
    start = 1'b1; decrypt = 1'b1;
    exp_load.push_back(c0 + 1);
    push_rounds(c0 + 2, 1'b1, 99, 0, 16);
    exp_final.push_back(c0 + 18);
    exp_done.push_back(c0 + 19);
    go_cycle();
    start = 1'b0; decrypt = 1'b0;
    @(negedge clk);
    total++;
    if (key_dir !== 1'b1) begin
      bad++;
      $display("FAIL dec_dir: key_dir=%b required=1", key_dir);
    end
    wait_rel(c0, 21);
    @(negedge clk);
    total++;
    if (pending() != 0) begin
      bad++;
      $display("FAIL dec_pending: pending=%0d required=0", pending());
    end
  endtask

  task automatic test_stall();
    int c0;
    go_cycle();
    c0 = cyc;
    start = 1'b1; decrypt = 1'b0;
    exp_load.push_back(c0 + 1);
    push_rounds(c0 + 2, 1'b0, 7, 3, 16);
    exp_final.push_back(c0 + 21);
    exp_done.push_back(c0 + 22);
    go_cycle();
    start = 1'b0;
    wait_rel(c0, 9);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (round_en !== 1'b0 || round_idx !== 4'd7) begin
        bad++;
        $display("FAIL stall_hold%0d: round_en=%b idx=%0d required round_en=0 idx=7",
                 k, round_en, round_idx);
      end
      go_cycle();
    end
    stall = 1'b0;
    wait_rel(c0, 23);
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || pending() != 0) begin
      bad++;
      $display("FAIL stall_end: ready=%b pending=%0d required ready=1 pending=0", ready, pending());
    end
  endtask

  task automatic test_load_stall();
    int c0;
    go_cycle();
    c0 = cyc;
    start = 1'b1; decrypt = 1'b1; stall = 1'b1;
    exp_load.push_back(c0 + 1);
    exp_load.push_back(c0 + 2);
    push_rounds(c0 + 3, 1'b1, 99, 0, 16);
    exp_final.push_back(c0 + 19);
    exp_done.push_back(c0 + 20);
    go_cycle();
    start = 1'b0;
    go_cycle();
    stall = 1'b0;
    @(negedge clk);
    total++;
    if (load_en !== 1'b1 || round_idx !== 4'd0) begin
      bad++;
      $display("FAIL load_stall: load_en=%b idx=%0d required load_en=1 idx=0", load_en, round_idx);
    end
    wait_rel(c0, 19);
    stall = 1'b1;
    go_cycle();
    stall = 1'b0;
    wait_rel(c0, 22);
    @(negedge clk);
    total++;
    if (pending() != 0) begin
      bad++;
      $display("FAIL load_stall_pending: pending=%0d required=0", pending());
    end
  endtask

  task automatic test_ignored_start();
    int c0;
    go_cycle();
    c0 = cyc;
    start = 1'b1; decrypt = 1'b0;
    exp_load.push_back(c0 + 1);
    push_rounds(c0 + 2, 1'b0, 99, 0, 16);
    exp_final.push_back(c0 + 18);
    exp_done.push_back(c0 + 19);
    go_cycle();
    start = 1'b0;
    wait_rel(c0, 5);
    start = 1'b1;
    go_cycle();
    start = 1'b0;
    wait_rel(c0, 10);
    decrypt = 1'b1;
    wait_rel(c0, 15);
    @(negedge clk);
    total++;
    if (key_dir !== 1'b0) begin
      bad++;
      $display("FAIL ign_dir: key_dir=%b required=0", key_dir);
    end
    wait_rel(c0, 19);
    start = 1'b1;
    go_cycle();
    start = 1'b0; decrypt = 1'b0;
    wait_rel(c0, 30);
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || pending() != 0) begin
      bad++;
      $display("FAIL ign_end: ready=%b pending=%0d required ready=1 pending=0", ready, pending());
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    logic [6:0] got;
    go_cycle();
    c0 = cyc;
    start = 1'b1; decrypt = 1'b1;
    exp_load.push_back(c0 + 1);
    push_rounds(c0 + 2, 1'b1, 99, 0, 10);
    go_cycle();
    start = 1'b0; decrypt = 1'b0;
    wait_rel(c0, 11);
    rst = 1'b1;
    go_cycle();
    rst = 1'b0;
    @(negedge clk);
    got = {ready, busy, key_dir, round_idx};
    total++;
    if (got !== 7'b1_0_0_0000) begin
      bad++;
      $display("FAIL rstmid_outputs: {ready,busy,dir,idx}=%b required=%b", got, 7'b1_0_0_0000);
    end
    wait_rel(c0, 30);
    @(negedge clk);
    total++;
    if (pending() != 0) begin
      bad++;
      $display("FAIL rstmid_pending: pending=%0d required=0", pending());
    end
    go_cycle();
    c0 = cyc;
    start = 1'b1; decrypt = 1'b0;
    exp_load.push_back(c0 + 1);
    push_rounds(c0 + 2, 1'b0, 99, 0, 16);
    exp_final.push_back(c0 + 18);
    exp_done.push_back(c0 + 19);
    go_cycle();
    start = 1'b0;
    wait_rel(c0, 21);
    @(negedge clk);
    total++;
    if (pending() != 0) begin
      bad++;
      $display("FAIL rstmid_rerun: pending=%0d required=0", pending());
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    go_cycle();
    c0 = cyc;
    start = 1'b1; decrypt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_load.push_back(c0 + 20 * k + 1);
      push_rounds(c0 + 20 * k + 2, 1'b0, 99, 0, 16);
      exp_final.push_back(c0 + 20 * k + 18);
      exp_done.push_back(c0 + 20 * k + 19);
    end
    wait_rel(c0, 41);
    start = 1'b0;
    wait_rel(c0, 62);
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || pending() != 0) begin
      bad++;
      $display("FAIL b2b_end: ready=%b pending=%0d required ready=1 pending=0", ready, pending());
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_stall();
    test_load_stall();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    go_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_round_ctrl.md
DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 The block SHALL have no parameters; the round count is fixed at 16.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to process one 64-bit block; sampled only in IDLE.
REQ-005 decrypt  input  1  0 = encrypt, 1 = decrypt; captured with an accepted start.
REQ-006 stall  input  1  freezes sequencing in LOAD and ROUND states.
REQ-007 ready  output  1  high only in IDLE.
REQ-008 busy  output  1  high in LOAD, ROUND and FINAL.
REQ-009 load_en  output  1  datapath captures the IP-permuted block and PC-1 key halves.
REQ-010 round_en  output  1  datapath updates L/R and C/D registers for one round.
REQ-011 round_idx  output  4  current round, 0..15.
REQ-012 key_shift  output  2  rotation amount (0, 1 or 2) applied to C/D this round.
REQ-013 key_dir  output  1  0 = rotate left, 1 = rotate right; equals latched decrypt.
REQ-014 final_swap  output  1  datapath applies the R16/L16 swap and FP into the output register.
REQ-015 done  output  1  one-cycle pulse; the result register is valid from this cycle.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, ROUND, FINAL and DONE, binary-encoded, with IDLE as the reset state.
REQ-017 In IDLE with start=1, the block SHALL latch decrypt and go to LOAD on the next edge.
REQ-018 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-019 In LOAD, load_en SHALL be 1 and round_idx SHALL be 0; if stall=0 the next state SHALL be ROUND, otherwise the block SHALL stay in LOAD with load_en still asserted.
REQ-020 In ROUND, round_en SHALL equal !stall; round_idx SHALL increment only on non-stalled cycles.
REQ-021 When round_idx=15 and stall=0, the next state SHALL be FINAL and round_idx SHALL wrap to 0.
REQ-022 In FINAL, final_swap SHALL be 1 for exactly one cycle (stall ignored), then the state SHALL go to DONE.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-024 With no stall, latency SHALL be 19 cycles from the start-sampling edge to done=1: LOAD at cycle 1, ROUND at cycles 2-17, FINAL at 18, DONE at 19.
REQ-025 key_shift SHALL be valid whenever round_en=1 and SHALL be 0 in all other states.
REQ-026 Encrypt shift schedule (key_dir=0) by round_idx: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (total 28).
REQ-027 Decrypt shift schedule (key_dir=1) by round_idx: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (total 27).
REQ-028 start asserted while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-029 decrypt changes after acceptance SHALL NOT affect key_dir or key_shift for the block in flight.
REQ-030 Back-to-back operation: start=1 in the cycle after done SHALL be accepted, giving one block per 20 cycles.
REQ-031 load_en, round_en, final_swap and done SHALL be mutually exclusive in every cycle.
REQ-032 All outputs SHALL be registered or decoded purely from state/counter registers, with no combinational path from start, decrypt or stall to outputs, except round_en, which depends on stall.

Reset
REQ-033 rst=1 SHALL force the following on the next edge, from any state including mid-round: state=IDLE, round_idx=0, latched decrypt=0, ready=1, busy=0, load_en=0, round_en=0, key_shift=0, key_dir=0, final_swap=0, done=0.
REQ-034 rst SHALL take priority over start and stall in the same cycle.
REQ-035 An operation aborted by reset SHALL produce no done pulse.

Verification
REQ-036 Encrypt: start=1, decrypt=0 for one cycle -> load_en at cycle 1; round_en cycles 2-17 with key_shift 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; final_swap at 18; done at 19; ready at 20.
REQ-037 Decrypt: start=1, decrypt=1 -> key_dir=1 and key_shift 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 on the round_en cycles; done at 19.
REQ-038 Stall: stall=1 for 3 cycles while round_idx=7 -> round_en=0 and round_idx held at 7 for those 3 cycles; done at 22.
REQ-039 Ignored start: start pulses at cycles 5 and 19 of an operation, and decrypt toggles at cycle 10 -> neither start is accepted; schedule unchanged; exactly one done.
REQ-040 Reset mid-operation: rst=1 when round_idx=9 -> next cycle ready=1, round_idx=0, no done; a subsequent start completes normally in 19 cycles.
REQ-041 Back-to-back: start held high continuously -> done at cycles 19, 39, 59; load_en at 1, 21, 41.
